mix_columns_scheduler: RTL and testbench
========================================

Name: mix_columns_scheduler

Overview:
Iterative controller that time-shares one MixColumns column unit across the four columns of a 128-bit AES state. It sits between the ShiftRows output and the AddRoundKey stage in the round pipeline. It is not combinational: the block captures a state, sequences the columns through the shared unit, and presents the result on a valid/ready handshake. This replaces delay-driven column evaluation with clocked, deterministic latency.

Parameters:
- COLS_PER_CYCLE, 1: columns mixed per BUSY cycle. Legal values are 1, 2 and 4. Any other value is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  inState is valid.
- in_ready  output  1  block can accept inState.
- inState  input  128  state: byte (row r, col c) = bits [32c+8r+7 : 32c+8r].
- out_valid  output  1  outState is valid.
- out_ready  input  1  consumer accepts outState.
- outState  output  128  mixed state, same byte layout as inState.
- busy  output  1  FSM is in BUSY.

Behaviour:
- Reset values: FSM = IDLE, col_cnt = 0, state register = 0, outState = 0, out_valid = 0, busy = 0. in_ready = 1 after reset.
- Reset mid-operation aborts immediately. Partial results are discarded and no out_valid is produced.
- FSM states:
  - IDLE: in_ready = 1. Accept when in_valid && in_ready: capture inState into the working register, set col_cnt = 0, go to BUSY.
  - BUSY: each cycle, columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 pass through the column unit(s) and are written back in place. col_cnt advances by COLS_PER_CYCLE.
    - When the last column is written (col_cnt + COLS_PER_CYCLE == 4), go to DONE and set out_valid = 1 on the same edge.
    - col_cnt wraps to 0 on that edge.
  - DONE: out_valid = 1. outState = working register, held stable until out_ready.
    - If out_ready && !in_valid: go to IDLE, out_valid = 0.
    - If out_ready && in_valid: back-to-back accept. in_ready = 1 combinationally in DONE when out_ready = 1, so the new state is captured and the FSM goes directly to BUSY.
- in_ready = (IDLE) || (DONE && out_ready). in_ready is 0 in BUSY; in_valid is ignored there.
- Latency from accept edge to out_valid: 4/COLS_PER_CYCLE cycles (4, 2 or 1).
- Peak throughput: one state per 4/COLS_PER_CYCLE + 1 cycles without stalls.
- Column arithmetic, GF(2^8) with modulus 0x11B:
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0), truncated to 8 bits.
  - out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), row indices mod 4.
- outState changes only on the DONE-entry edge, never while out_valid && !out_ready.
- No $display or # delays in synthesizable code.

Optional Feature:
- Macro: MIX_COLUMNS_INV_EN.
- Defined:
  - Adds input port inv (1 bit), sampled on the accept edge and held for the whole operation.
  - inv = 1 selects InvMixColumns with coefficients {0E,0B,0D,09}, computed via a chained xtime in the column unit.
  - Latency and handshake are unchanged.
- Undefined:
  - No inv port exists.
  - Forward MixColumns only.

Decomposition:
- Package aes_pkg holds:
  - the state_t (128-bit) and col_t (32-bit) typedefs;
  - the fsm_t enum {IDLE, BUSY, DONE};
  - the GF_POLY = 8'h1B constant;
  - the xtime function.
- One sub-module, mix_single_column: purely combinational 32→32 forward/inverse column mixer with an inv input, tied to 0 when the macro is off. The scheduler instantiates it COLS_PER_CYCLE times.

Test Plan:
1. FIPS-197 columns, COLS_PER_CYCLE = 1.
   - Input: inState = 0xd5d4d4d4_01010101_5c220af2_455313db.
   - Required: outState = 0xd6d7d5d5_01010101_9d58dc9f_bca14d8e, out_valid asserted exactly 4 cycles after accept.
2. Backpressure.
   - Stimulus: hold out_ready = 0 for 10 cycles after out_valid.
   - Required: outState stable, in_ready = 0 throughout; a single accept occurs on the out_ready edge.
3. Back-to-back.
   - Stimulus: in_valid held high, out_ready = 1, two states 0x0...0 and the vector from test 1.
   - Required: second accept on the same edge as the first handoff; outputs 0x0...0 then the expected vector; a 5-cycle period.
4. Async reset asserted in BUSY at col_cnt = 2.
   - Required: out_valid = 0 and in_ready = 1 immediately; no output for the aborted state.
5. COLS_PER_CYCLE = 2 and 4, vector from test 1.
   - Required: identical outState with latency 2 and 1 respectively.
6. With MIX_COLUMNS_INV_EN and inv = 1.
   - Input: 0xd6d7d5d5_01010101_9d58dc9f_bca14d8e.
   - Required: 0xd5d4d4d4_01010101_5c220af2_455313db.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES round types, FSM encoding and GF(2^8) helpers.
// Used by the MixColumns scheduler and its column unit.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_scheduler_if.sv
// Input/output valid-ready bundle of the MixColumns scheduler.
// slave = scheduler side, master = producer/consumer side.
interface mix_columns_scheduler_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t inState;
  logic   out_valid;
  logic   out_ready;
  state_t outState;

  modport master (
    output in_valid,
    output inState,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  outState
  );

  modport slave (
    input  in_valid,
    input  inState,
    input  out_ready,
    output in_ready,
    output out_valid,
    output outState
  );

endinterface

// File: rtl/mix_single_column.sv
// Combinational 32-bit column mixer, forward or inverse MixColumns.
// Inverse coefficients are built from a chained xtime (x2, x4, x8).
module mix_single_column
  import aes_pkg::*;
(
  input  col_t i_col,
  input  logic i_inv,
  output col_t o_col
);

  logic [7:0] w_a  [4];
  logic [7:0] w_x2 [4];
  logic [7:0] w_x4 [4];
  logic [7:0] w_x8 [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;

    logic [7:0] w_fwd;
    logic [7:0] w_inv;

    assign w_a[r]  = i_col[8*r +: 8];
    assign w_x2[r] = xtime(w_a[r]);
    assign w_x4[r] = xtime(w_x2[r]);
    assign w_x8[r] = xtime(w_x4[r]);

    assign w_fwd = w_x2[r]
                 ^ w_x2[R1] ^ w_a[R1]
                 ^ w_a[R2]
                 ^ w_a[R3];

    // 0E, 0B, 0D, 09 applied to rows r, r+1, r+2, r+3
    assign w_inv = (w_x8[r] ^ w_x4[r] ^ w_x2[r])
                 ^ (w_x8[R1] ^ w_x2[R1] ^ w_a[R1])
                 ^ (w_x8[R2] ^ w_x4[R2] ^ w_a[R2])
                 ^ (w_x8[R3] ^ w_a[R3]);

    assign o_col[8*r +: 8] = i_inv ? w_inv : w_fwd;
  end

endmodule

// File: rtl/mix_columns_scheduler.sv
// Time-shares COLS_PER_CYCLE column units over a 128-bit AES state.
// Define MIX_COLUMNS_INV_EN to add the inv port (InvMixColumns).
module mix_columns_scheduler
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef MIX_COLUMNS_INV_EN
  input  logic inv,
`endif
  mix_columns_scheduler_if.slave bus,
  output logic busy
);

  if (COLS_PER_CYCLE != 1 &&
      COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $fatal(1, "COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  fsm_t       r_state;
  fsm_t       w_state_nxt;
  logic [1:0] r_col_cnt;
  state_t     r_work;
  state_t     r_out;
  state_t     w_work_nxt;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_last;
  logic [2:0] w_cnt_sum;
  logic       w_inv;

  col_t w_col_in  [COLS_PER_CYCLE];
  col_t w_col_out [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_INV_EN
  logic r_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_inv <= 1'b0;
    else if (w_accept) r_inv <= inv;
  end

  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  assign w_cnt_sum = {1'b0, r_col_cnt} + STEP;
  assign w_last    = (w_cnt_sum == 3'd4);
  assign w_accept  = bus.in_valid && w_in_ready;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_col_in[k] =
      r_work[{r_col_cnt + 2'(k), 5'b0} +: 32];

    mix_single_column u_mix (
      .i_col (w_col_in[k]),
      .i_inv (w_inv),
      .o_col (w_col_out[k])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_work_nxt[{r_col_cnt + 2'(k), 5'b0} +: 32] =
        w_col_out[k];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        // a waiting input is taken on the handoff edge
        if (bus.out_ready) begin
          w_in_ready  = 1'b1;
          w_state_nxt = bus.in_valid ? BUSY : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col_cnt <= 2'd0;
      r_work    <= '0;
      r_out     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work    <= bus.inState;
        r_col_cnt <= 2'd0;
      end else if (r_state == BUSY) begin
        r_work    <= w_work_nxt;
        r_col_cnt <= w_cnt_sum[1:0];
        if (w_last) r_out <= w_work_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.outState  = r_out;
  assign busy          = (r_state == BUSY);

endmodule

// File: tb/tb_mix_columns_scheduler.sv
// Randomized + directed bench for mix_columns_scheduler.
// Reference is a GF(2^8) multiply model over whole states.
module tb_mix_columns_scheduler;
  import aes_pkg::*;

  localparam state_t VEC_IN =
    128'hd5d4d4d4_01010101_5c220af2_455313db;
  localparam state_t VEC_OUT =
    128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e;

  logic clk = 1'b0;
  logic rst;
  logic aux_valid;
  logic aux_ready;
  logic tb_inv;
  logic busy1, busy2, busy4;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mix_columns_scheduler_if bus ();
  mix_columns_scheduler_if bus2 ();
  mix_columns_scheduler_if bus4 ();

  assign bus2.in_valid  = aux_valid;
  assign bus2.inState   = bus.inState;
  assign bus2.out_ready = aux_ready;
  assign bus4.in_valid  = aux_valid;
  assign bus4.inState   = bus.inState;
  assign bus4.out_ready = aux_ready;

  mix_columns_scheduler #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
`ifdef MIX_COLUMNS_INV_EN
    .inv  (tb_inv),
`endif
    .bus  (bus),
    .busy (busy1)
  );

  mix_columns_scheduler #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
`ifdef MIX_COLUMNS_INV_EN
    .inv  (tb_inv),
`endif
    .bus  (bus2),
    .busy (busy2)
  );

  mix_columns_scheduler #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
`ifdef MIX_COLUMNS_INV_EN
    .inv  (tb_inv),
`endif
    .bus  (bus4),
    .busy (busy4)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] x;
    logic [7:0] p;
    x = {1'b0, a};
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11B;
    end
    return p;
  endfunction

  function automatic state_t ref_mix(
    input state_t s,
    input logic   inv_sel
  );
    logic [7:0] cf [4];
    logic [7:0] acc;
    state_t     res;
    if (inv_sel) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(cf[k], s[32*c + 8*((r+k)%4) +: 8]);
        res[32*c + 8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic state_t rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid) chk("timeout", 128'(bus.out_valid), 128'd1);
  endtask

  initial begin
    state_t x, held, o1, o2, o4;
    state_t q[$];
    int     n, l1, l2, l4, t1, t2;
    logic   ok_a, ok_b, cur_inv, stall;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inState   = '0;
    bus.out_ready = 1'b0;
    aux_valid = 1'b0;
    aux_ready = 1'b0;
    tb_inv    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_busy", 128'(busy1), 128'd0);
    chk("rst_outState", bus.outState, 128'd0);

    // FIPS vector on all three widths
    @(negedge clk);
    bus.inState  = VEC_IN;
    bus.in_valid = 1'b1;
    aux_valid    = 1'b1;
    #1;
    chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    aux_valid    = 1'b0;
    chk("busy_after_accept", 128'(busy1), 128'd1);
    l1 = -1; l2 = -1; l4 = -1;
    o1 = '0; o2 = '0; o4 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid && l1 < 0) begin
        l1 = i; o1 = bus.outState;
      end
      if (bus2.out_valid && l2 < 0) begin
        l2 = i; o2 = bus2.outState;
      end
      if (bus4.out_valid && l4 < 0) begin
        l4 = i; o4 = bus4.outState;
      end
    end
    chk("lat_c1", 128'(l1), 128'd4);
    chk("lat_c2", 128'(l2), 128'd2);
    chk("lat_c4", 128'(l4), 128'd1);
    chk("fips_c1", o1, VEC_OUT);
    chk("fips_c2", o2, ref_mix(VEC_IN, 1'b0));
    chk("fips_c4", o4, ref_mix(VEC_IN, 1'b0));
    aux_ready = 1'b1;

    // backpressure with a pending input
    held = bus.outState;
    x = rnd_state();
    bus.inState  = x;
    bus.in_valid = 1'b1;
    ok_a = 1'b1;
    ok_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.outState !== held || !bus.out_valid) ok_a = 1'b0;
      if (bus.in_ready) ok_b = 1'b0;
    end
    chk("stall_stable", 128'(ok_a), 128'd1);
    chk("stall_in_ready_low", 128'(ok_b), 128'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("handoff_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("handoff_busy", 128'(busy1), 128'd1);
    chk("handoff_valid_low", 128'(bus.out_valid), 128'd0);
    wait_valid(n);
    chk("bp_lat", 128'(n), 128'd4);
    chk("bp_data", bus.outState, ref_mix(x, 1'b0));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_idle", 128'(bus.out_valid), 128'd0);

    // back-to-back: zero state then FIPS vector
    bus.inState  = '0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inState = VEC_IN;
    wait_valid(n);
    t1 = cyc;
    chk("b2b_first", bus.outState, 128'd0);
    chk("b2b_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_busy", 128'(busy1), 128'd1);
    wait_valid(n);
    t2 = cyc;
    chk("b2b_second", bus.outState, VEC_OUT);
    chk("b2b_period", 128'(t2 - t1), 128'd5);
    @(posedge clk);
    @(negedge clk);

    // async reset at col_cnt = 2
    bus.inState  = rnd_state();
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
    chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
    chk("abort_busy", 128'(busy1), 128'd0);
    chk("abort_outState", bus.outState, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ok_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) ok_a = 1'b1;
    end
    chk("abort_no_output", 128'(ok_a), 128'd0);

`ifdef MIX_COLUMNS_INV_EN
    bus.out_ready = 1'b0;
    bus.inState   = VEC_OUT;
    bus.in_valid  = 1'b1;
    tb_inv        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tb_inv       = 1'b0;
    wait_valid(n);
    chk("inv_fips", bus.outState, VEC_IN);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
`endif

    // randomized traffic against a queue scoreboard
    stall = 1'b0;
    held  = '0;
    for (int i = 0; i < 400; i++) begin
      if (stall) begin
        chk("hold_valid", 128'(bus.out_valid), 128'd1);
        chk("hold_data", bus.outState, held);
      end
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.inState   = rnd_state();
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MIX_COLUMNS_INV_EN
      tb_inv  = 1'($urandom_range(0, 1));
      cur_inv = tb_inv;
`else
      cur_inv = 1'b0;
`endif
      #1;
      stall = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (q.size() == 0)
            chk("rnd_spurious", 128'(q.size()), 128'd1);
          else
            chk("rnd_data", bus.outState, q.pop_front());
        end else begin
          stall = 1'b1;
          held  = bus.outState;
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_mix(bus.inState, cur_inv));
      @(posedge clk);
      @(negedge clk);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      #1;
      if (bus.out_valid)
        chk("drain_data", bus.outState, q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    chk("drain_empty", 128'(q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
